reg_wb_buffer: RTL and testbench

REG_WB_BUFFER -- requirements
Module: reg_wb_buffer

---
 rtl/mips_pkg.sv | 6 +
 rtl/wb_bypass_lookup.sv | 35 +++
 rtl/reg_wb_buffer.sv | 97 +++++++++
 tb/tb_reg_wb_buffer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath widths and architectural constants.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/wb_bypass_lookup.sv
// Youngest-match search over the occupied writeback slots for one read port.
module wb_bypass_lookup #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic [PTR_W-1:0]              rd_ptr,
  input  logic [CNT_W-1:0]              count,
  input  logic [DEPTH-1:0][ADDR_W-1:0]  slot_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]  slot_data,
  input  logic [ADDR_W-1:0]             lookup_addr,
  output logic                          hit,
  output logic [DATA_W-1:0]             data
);
  import mips_pkg::REG_ZERO;

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < count && slot_addr[idx] == lookup_addr &&
          lookup_addr != ADDR_W'(REG_ZERO)) begin
        hit  = 1'b1;
        data = slot_data[idx];
      end
    end
  end
endmodule

// File: rtl/reg_wb_buffer.sv
// Register writeback FIFO: queues writebacks until the RF write port is granted
// and exposes the youngest pending value on two bypass read ports.
module reg_wb_buffer #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      rf_grant,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  input  logic [ADDR_W-1:0]         byp_addr_1,
  input  logic [ADDR_W-1:0]         byp_addr_2,
  output logic                      byp_hit_1,
  output logic                      byp_hit_2,
  output logic [DATA_W-1:0]         byp_data_1,
  output logic [DATA_W-1:0]         byp_data_2,
  output logic [$clog2(DEPTH):0]    count
);
  import mips_pkg::REG_ZERO;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NUM_RD = 2;

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [CNT_W-1:0]             cnt_q;
  logic                         push, pop;

  assign in_ready = cnt_q < CNT_W'(DEPTH);
  assign rf_we    = (cnt_q != '0) && rf_grant;
  assign rf_waddr = addr_q[rd_ptr];
  assign rf_wdata = data_q[rd_ptr];
  assign count    = cnt_q;

  // Writes to r0 complete the handshake but never occupy a slot.
  assign push = in_valid && in_ready && (in_addr != ADDR_W'(REG_ZERO));
  assign pop  = rf_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        addr_q[wr_ptr] <= in_addr;
        data_q[wr_ptr] <= in_data;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  logic [NUM_RD-1:0][ADDR_W-1:0] byp_addr;
  logic [NUM_RD-1:0]             byp_hit;
  logic [NUM_RD-1:0][DATA_W-1:0] byp_data;

  assign byp_addr = {byp_addr_2, byp_addr_1};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_byp
    wb_bypass_lookup #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH)
    ) u_lookup (
      .rd_ptr     (rd_ptr),
      .count      (cnt_q),
      .slot_addr  (addr_q),
      .slot_data  (data_q),
      .lookup_addr(byp_addr[p]),
      .hit        (byp_hit[p]),
      .data       (byp_data[p])
    );
  end

  assign byp_hit_1  = byp_hit[0];
  assign byp_hit_2  = byp_hit[1];
  assign byp_data_1 = byp_data[0];
  assign byp_data_2 = byp_data[1];
endmodule

// File: tb/tb_reg_wb_buffer.sv
// Scoreboard bench for reg_wb_buffer: a queue of pending writes predicts every
// output each cycle; directed phases cover the handshake, full, r0, wrap and reset cases.
module tb_reg_wb_buffer;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          rf_grant;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] byp_addr_1, byp_addr_2;
  logic          byp_hit_1, byp_hit_2;
  logic [DW-1:0] byp_data_1, byp_data_2;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  reg_wb_buffer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .rf_grant(rf_grant), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .byp_addr_1(byp_addr_1), .byp_addr_2(byp_addr_2),
    .byp_hit_1(byp_hit_1), .byp_hit_2(byp_hit_2),
    .byp_data_1(byp_data_1), .byp_data_2(byp_data_2),
    .count(count)
  );

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t q[$];

  int n_chk = 0, n_fail = 0, we_cnt = 0;
  bit rand_byp = 0;
  logic [DW-1:0] rf_img [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void byp_model(input logic [AW-1:0] a, output logic h, output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
    if (a != 0)
      foreach (q[i])
        if (q[i].a == a) begin h = 1'b1; d = q[i].d; end
  endfunction

  // Model update on the accepting edge; inputs only change at negedge+1.
  always @(posedge clk) begin
    bit do_pop, do_push;
    if (rst_n) begin
      do_pop  = q.size() > 0 && rf_grant;
      do_push = in_valid && q.size() < DEPTH && in_addr != 0;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{a: in_addr, d: in_data});
    end
  end

  always @(negedge clk) begin
    logic h;
    logic [DW-1:0] d;
    chk("count", count, q.size());
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("rf_we", rf_we, q.size() > 0 && rf_grant);
    if (q.size() > 0) begin
      chk("rf_waddr", rf_waddr, q[0].a);
      chk("rf_wdata", rf_wdata, q[0].d);
    end
    byp_model(byp_addr_1, h, d);
    chk("byp_hit_1", byp_hit_1, h);
    chk("byp_data_1", byp_data_1, d);
    byp_model(byp_addr_2, h, d);
    chk("byp_hit_2", byp_hit_2, h);
    chk("byp_data_2", byp_data_2, d);
    if (rf_we) begin
      rf_img[rf_waddr] = rf_wdata;
      we_cnt++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
    if (rand_byp) begin
      byp_addr_1 = AW'($urandom_range(0, 7));
      byp_addr_2 = AW'($urandom_range(0, 7));
    end
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit acc;
    int n;
    in_valid = 1'b1; in_addr = a; in_data = d; n = 0;
    do begin
      #1;
      acc = in_ready;
      step();
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    rf_grant = 1'b1;
    while (q.size() > 0 && n < 50) begin step(); n++; end
    #1;
    chk("drain_count", count, 0);
  endtask

  initial begin
    foreach (rf_img[i]) rf_img[i] = '0;
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    rf_grant = 1'b0; byp_addr_1 = '0; byp_addr_2 = '0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rf_we", rf_we, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Single write with grant: written one cycle after acceptance.
    rf_grant = 1'b1;
    #1 chk("t1_in_ready", in_ready, 1);
    send(5'd3, 32'h11);
    #1;
    chk("t1_we", rf_we, 1);
    chk("t1_waddr", rf_waddr, 3);
    chk("t1_wdata", rf_wdata, 32'h11);
    step();
    chk("t1_count", count, 0);
    chk("t1_rf3", rf_img[3], 32'h11);

    // Fill with grant low, fifth offer must stall.
    rf_grant = 1'b0;
    for (int i = 0; i < 4; i++) send(AW'(i + 1), 32'h100 + i);
    in_valid = 1'b1; in_addr = 5'd9; in_data = 32'h199;
    step(); step();
    chk("t2_full_ready", in_ready, 0);
    chk("t2_full_count", count, 4);
    rf_grant = 1'b1;
    in_valid = 1'b0;
    step();
    chk("t2_ready_after_pop", in_ready, 1);
    send(5'd9, 32'h199);
    drain();
    chk("t2_rf4", rf_img[4], 32'h103);
    chk("t2_rf9", rf_img[9], 32'h199);

    // Youngest-match bypass; an offered write does not bypass.
    rf_grant = 1'b0;
    send(5'd7, 32'hA);
    send(5'd7, 32'hB);
    byp_addr_1 = 5'd7;
    in_valid = 1'b1; in_addr = 5'd7; in_data = 32'hC;
    #1;
    chk("t3_hit", byp_hit_1, 1);
    chk("t3_data_young", byp_data_1, 32'hB);
    in_valid = 1'b0;
    drain();
    chk("t3_rf7", rf_img[7], 32'hB);
    chk("t3_hit_after", byp_hit_1, 0);

    // r0 writes are swallowed.
    rf_grant = 1'b0;
    byp_addr_2 = 5'd0;
    send(5'd0, 32'hFFFF);
    #1;
    chk("t4_count", count, 0);
    chk("t4_we", rf_we, 0);
    chk("t4_hit2", byp_hit_2, 0);
    rf_grant = 1'b1;
    step();
    chk("t4_we_grant", rf_we, 0);

    // Steady push+pop at count 2 across pointer wrap.
    rf_grant = 1'b0;
    send(5'd10, 32'h200);
    send(5'd11, 32'h201);
    rf_grant = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_addr = AW'(12 + i); in_data = 32'h300 + i;
      #1 chk("t5_count", count, 2);
      step();
    end
    in_valid = 1'b0;
    drain();
    chk("t5_rf19", rf_img[19], 32'h307);

    // Reset mid-operation discards pending entries.
    rf_grant = 1'b0;
    send(5'd20, 32'h400);
    send(5'd21, 32'h401);
    send(5'd22, 32'h402);
    byp_addr_1 = 5'd21;
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("t6_count", count, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_hit", byp_hit_1, 0);
    chk("t6_data", byp_data_1, 0);
    rf_grant = 1'b1;
    #1 chk("t6_we_in_rst", rf_we, 0);
    step();
    we_cnt = 0;
    rst_n = 1'b1;
    repeat (5) step();
    chk("t6_no_we", we_cnt, 0);
    chk("t6_rf21", rf_img[21], 0);

    // Random traffic over a small address range.
    rand_byp = 1'b1;
    for (int i = 0; i < 200; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_addr  = AW'($urandom_range(0, 7));
      in_data  = $urandom;
      rf_grant = $urandom_range(0, 2) != 0;
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
